// File: rtl/mm_tile_multiplier.sv
// Row-serial tiled matrix multiplier: C = A*B or C += A*B, with A (MxK), B (KxN) and C (MxN)
// held row-major in one shared single-port BRAM. N MAC lanes produce one row of C per pass.
module mm_tile_multiplier #(
    parameter  int unsigned L_M      = 2,
    parameter  int unsigned L_K      = 2,
    parameter  int unsigned L_N      = 2,
    parameter  int unsigned BITWIDTH = 32,
    localparam int unsigned ADDR_W   =
        (((L_M + L_K) > (L_K + L_N))
            ? (((L_M + L_K) > (L_M + L_N)) ? (L_M + L_K) : (L_M + L_N))
            : (((L_K + L_N) > (L_M + L_N)) ? (L_K + L_N) : (L_M + L_N))) + 2
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    input  logic                accumulate,
    input  logic [BITWIDTH-1:0] rddata,
    output logic [ADDR_W-1:0]   addr,
    output logic [BITWIDTH-1:0] wrdata,
    output logic                we,
    output logic                busy,
    output logic                done
);

    localparam int unsigned M         = 1 << L_M;
    localparam int unsigned K         = 1 << L_K;
    localparam int unsigned N         = 1 << L_N;
    localparam int unsigned MK        = M * K;
    localparam int unsigned KN        = K * N;
    localparam int unsigned BASE_C    = MK + KN;
    localparam int unsigned LOAD_LAST = MK + KN;
    localparam int unsigned CNT_W     = ADDR_W;
    localparam int unsigned ROW_W     = L_M + 1;
    // Index widths are kept at least 1 bit so degenerate (size 1) dimensions stay legal
    localparam int unsigned AIW       = ((L_M + L_K) > 0) ? (L_M + L_K) : 1;
    localparam int unsigned BIW       = ((L_K + L_N) > 0) ? (L_K + L_N) : 1;
    localparam int unsigned LW        = (L_N > 0) ? L_N : 1;
    localparam int unsigned ACC_N     = 1 << LW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RDC,
        S_CALC,
        S_WRT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  mode_q, mode_d;
    logic [BITWIDTH-1:0]   acc_q [ACC_N];
    logic [BITWIDTH-1:0]   acc_d [ACC_N];
    logic [BITWIDTH-1:0]   abuf_q [1 << AIW];
    logic [BITWIDTH-1:0]   bbuf_q [1 << BIW];

    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BITWIDTH-1:0]   wrdata_q, wrdata_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign we     = we_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Next-state, MAC datapath and registered-output decode (outputs follow the next state)
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        addr_d   = '0;
        wrdata_d = '0;
        we_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = accumulate;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (32'(cnt_q) == LOAD_LAST) begin
                    cnt_d = '0;
                    row_d = '0;
                    if (mode_q) begin
                        state_d = S_RDC;
                    end else begin
                        state_d = S_CALC;
                        for (int j = 0; j < ACC_N; j++) acc_d[j] = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RDC: begin
                if (cnt_q != '0) acc_d[LW'(32'(cnt_q) - 1)] = rddata;
                if (32'(cnt_q) == N) begin
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CALC: begin
                for (int j = 0; j < N; j++) begin
                    acc_d[LW'(j)] = acc_q[LW'(j)]
                        + abuf_q[AIW'((32'(row_q) << L_K) + 32'(cnt_q))]
                        * bbuf_q[BIW'((32'(cnt_q) << L_N) + 32'(j))];
                end
                if (32'(cnt_q) == K - 1) begin
                    cnt_d   = '0;
                    state_d = S_WRT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRT: begin
                if (32'(cnt_q) == N - 1) begin
                    cnt_d = '0;
                    if (row_q == ROW_W'(M - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                        if (mode_q) begin
                            state_d = S_RDC;
                        end else begin
                            state_d = S_CALC;
                            for (int j = 0; j < ACC_N; j++) acc_d[j] = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_LOAD: begin
                if (32'(cnt_d) < LOAD_LAST) addr_d = ADDR_W'(cnt_d);
            end
            S_RDC: begin
                if (32'(cnt_d) < N) addr_d = ADDR_W'(BASE_C + (32'(row_d) << L_N) + 32'(cnt_d));
            end
            S_WRT: begin
                we_d     = 1'b1;
                addr_d   = ADDR_W'(BASE_C + (32'(row_d) << L_N) + 32'(cnt_d));
                wrdata_d = acc_d[LW'(cnt_d)];
            end
            default: begin
                addr_d = '0;
            end
        endcase
    end

    // Control state, counters and registered BRAM-side outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Lane accumulators
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int j = 0; j < ACC_N; j++) acc_q[j] <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Operand capture during LOAD; read data lags the issued address by one cycle
    always_ff @(posedge aclk) begin
        if (state_q == S_LOAD && cnt_q != '0) begin
            if (32'(cnt_q) <= MK) begin
                abuf_q[AIW'(32'(cnt_q) - 1)] <= rddata;
            end else begin
                bbuf_q[BIW'(32'(cnt_q) - 1 - MK)] <= rddata;
            end
        end
    end

endmodule

// File: tb/tb_mm_tile_multiplier.sv
// Directed bench: default 4x4x4 instance plus a rectangular 2x8x4 instance, each on its own BRAM model.
module tb_mm_tile_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start0 = 1'b0, acc0 = 1'b0, we0, busy0, done0;
    logic [5:0]  addr0;
    logic [31:0] wd0, rd0;
    logic        start1 = 1'b0, acc1 = 1'b0, we1, busy1, done1;
    logic [6:0]  addr1;
    logic [31:0] wd1, rd1;

    logic        tw0 = 1'b0, tw1 = 1'b0;
    logic [5:0]  ta0 = '0;
    logic [6:0]  ta1 = '0;
    logic [31:0] td0 = '0, td1 = '0;
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [128];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mm_tile_multiplier u_dut0 (
        .aclk(clk), .aresetn(rst_n), .start(start0), .accumulate(acc0), .rddata(rd0),
        .addr(addr0), .wrdata(wd0), .we(we0), .busy(busy0), .done(done0)
    );

    mm_tile_multiplier #(.L_M(1), .L_K(3), .L_N(2), .BITWIDTH(32)) u_dut1 (
        .aclk(clk), .aresetn(rst_n), .start(start1), .accumulate(acc1), .rddata(rd1),
        .addr(addr1), .wrdata(wd1), .we(we1), .busy(busy1), .done(done1)
    );

    // Single-port BRAMs with one-cycle read latency and a bench preload port
    always @(posedge clk) begin
        if (tw0) mem0[ta0] <= td0;
        else if (we0) mem0[addr0] <= wd0;
        rd0 <= mem0[addr0];
    end

    always @(posedge clk) begin
        if (tw1) mem1[ta1] <= td1;
        else if (we1) mem1[addr1] <= wd1;
        rd1 <= mem1[addr1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_mem(input int sel, input int a, input logic [31:0] d);
        @(negedge clk);
        if (sel == 0) begin tw0 = 1'b1; ta0 = 6'(a); td0 = d; end
        else          begin tw1 = 1'b1; ta1 = 7'(a); td1 = d; end
        @(posedge clk); #1;
        tw0 = 1'b0;
        tw1 = 1'b0;
    endtask

    task automatic set_start(input int sel, input logic s, input logic a);
        if (sel == 0) begin start0 = s; acc0 = a; end
        else          begin start1 = s; acc1 = a; end
    endtask

    function automatic logic get_we(input int sel);   return (sel == 0) ? we0 : we1;     endfunction
    function automatic logic get_busy(input int sel); return (sel == 0) ? busy0 : busy1; endfunction
    function automatic logic get_done(input int sel); return (sel == 0) ? done0 : done1; endfunction
    function automatic logic [31:0] get_addr(input int sel);
        return (sel == 0) ? 32'(addr0) : 32'(addr1);
    endfunction
    function automatic logic [31:0] get_wd(input int sel); return (sel == 0) ? wd0 : wd1; endfunction

    // Start a job and watch it; optionally poke start mid-job or assert reset on the Nth write
    task automatic run_job(input int sel, input logic acc, input int poke, input int abort_we,
                           output int lat, output int wes, output int dones);
        lat = -1; wes = 0; dones = 0;
        @(negedge clk);
        set_start(sel, 1'b1, acc);
        @(posedge clk); #1;
        set_start(sel, 1'b0, 1'b0);
        check("busy_rise", 32'(get_busy(sel)), 32'd1);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (get_we(sel)) wes++;
            if (get_done(sel)) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    check("busy_in_done", 32'(get_busy(sel)), 32'd1);
                end
            end
            if (n == poke) set_start(sel, 1'b1, 1'b1);
            if (n == poke + 1) set_start(sel, 1'b0, 1'b0);
            if (abort_we > 0 && wes == abort_we) begin
                rst_n = 1'b0;
                #1;
                check("abort_addr", get_addr(sel), 32'd0);
                check("abort_wrdata", get_wd(sel), 32'd0);
                check("abort_we", 32'(get_we(sel)), 32'd0);
                check("abort_busy", 32'(get_busy(sel)), 32'd0);
                check("abort_done", 32'(get_done(sel)), 32'd0);
                break;
            end
            if (lat >= 0 && n == lat + 1) check("busy_fall", 32'(get_busy(sel)), 32'd0);
            if (lat >= 0 && n == lat + 6) break;
        end
    endtask

    initial begin
        int          lat, wes, dones;
        logic [31:0] ra [16];
        logic [31:0] rb [32];
        logic [31:0] s;
        logic [7:0]  r8;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_wrdata", wd0, 32'd0);
        check("rst_we", 32'(we0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity: C must equal B
        for (int i = 0; i < 16; i++) begin
            wr_mem(0, i, ((i / 4) == (i % 4)) ? 32'd1 : 32'd0);
            wr_mem(0, 16 + i, 32'(i + 1));
            wr_mem(0, 32 + i, 32'hFFFF_FFFF);
        end
        run_job(0, 1'b0, -1, 0, lat, wes, dones);
        check("ident_latency", 32'(lat), 32'd65);
        check("ident_we_count", 32'(wes), 32'd16);
        check("ident_done_count", 32'(dones), 32'd1);
        for (int i = 0; i < 16; i++) check($sformatf("ident_c%0d", i), mem0[32 + i], 32'(i + 1));

        // Accumulate twice: 5 + 4*2 = 13, then 13 + 8 = 21
        for (int i = 0; i < 16; i++) begin
            wr_mem(0, i, 32'd1);
            wr_mem(0, 16 + i, 32'd2);
            wr_mem(0, 32 + i, 32'd5);
        end
        run_job(0, 1'b1, -1, 0, lat, wes, dones);
        check("acc1_latency", 32'(lat), 32'd85);
        check("acc1_we_count", 32'(wes), 32'd16);
        for (int i = 0; i < 16; i++) check($sformatf("acc1_c%0d", i), mem0[32 + i], 32'd13);
        run_job(0, 1'b1, -1, 0, lat, wes, dones);
        check("acc2_latency", 32'(lat), 32'd85);
        check("acc2_done_count", 32'(dones), 32'd1);
        for (int i = 0; i < 16; i++) check($sformatf("acc2_c%0d", i), mem0[32 + i], 32'd21);

        // Signed wrap of a single product
        for (int i = 0; i < 16; i++) begin
            wr_mem(0, i, (i == 0) ? 32'h7FFF_FFFF : 32'd0);
            wr_mem(0, 16 + i, (i == 0) ? 32'd2 : 32'd0);
            wr_mem(0, 32 + i, 32'hAAAA_AAAA);
        end
        run_job(0, 1'b0, -1, 0, lat, wes, dones);
        check("wrap_latency", 32'(lat), 32'd65);
        for (int i = 0; i < 16; i++)
            check($sformatf("wrap_c%0d", i), mem0[32 + i], (i == 0) ? 32'hFFFF_FFFE : 32'd0);

        // Reset during the second row's write phase
        for (int i = 0; i < 16; i++) begin
            wr_mem(0, i, ((i / 4) == (i % 4)) ? 32'd1 : 32'd0);
            wr_mem(0, 16 + i, 32'(100 + i));
            wr_mem(0, 32 + i, 32'hDEAD_0000 + 32'(i));
        end
        run_job(0, 1'b0, -1, 6, lat, wes, dones);
        check("abort_no_done", 32'(dones), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold_done", 32'(done0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_after_done", 32'(done0), 32'd0);
        check("abort_after_busy", 32'(busy0), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("abort_row0_c%0d", i), mem0[32 + i], 32'(100 + i));
        for (int i = 8; i < 16; i++)
            check($sformatf("abort_keep_c%0d", i), mem0[32 + i], 32'hDEAD_0000 + 32'(i));
        run_job(0, 1'b0, -1, 0, lat, wes, dones);
        check("rerun_latency", 32'(lat), 32'd65);
        check("rerun_done_count", 32'(dones), 32'd1);
        for (int i = 0; i < 16; i++) check($sformatf("rerun_c%0d", i), mem0[32 + i], 32'(100 + i));

        // Start with accumulate=1 poked during CALC of an overwrite job is ignored
        for (int i = 0; i < 16; i++) begin
            wr_mem(0, i, 32'd1);
            wr_mem(0, 16 + i, 32'd2);
            wr_mem(0, 32 + i, 32'd5);
        end
        run_job(0, 1'b0, 35, 0, lat, wes, dones);
        check("poke_latency", 32'(lat), 32'd65);
        check("poke_done_count", 32'(dones), 32'd1);
        check("poke_we_count", 32'(wes), 32'd16);
        for (int i = 0; i < 16; i++) check($sformatf("poke_c%0d", i), mem0[32 + i], 32'd8);

        // Rectangular 2x8 * 8x4 with sign-extended random bytes
        for (int i = 0; i < 16; i++) begin
            r8 = 8'($urandom_range(0, 255));
            ra[i] = {{24{r8[7]}}, r8};
            wr_mem(1, i, ra[i]);
        end
        for (int i = 0; i < 32; i++) begin
            r8 = 8'($urandom_range(0, 255));
            rb[i] = {{24{r8[7]}}, r8};
            wr_mem(1, 16 + i, rb[i]);
        end
        for (int i = 0; i < 8; i++) wr_mem(1, 48 + i, 32'h5555_5555);
        run_job(1, 1'b0, -1, 0, lat, wes, dones);
        check("rect_latency", 32'(lat), 32'd73);
        check("rect_we_count", 32'(wes), 32'd8);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = '0;
                for (int k = 0; k < 8; k++) s = s + ra[i * 8 + k] * rb[k * 4 + j];
                check($sformatf("rect_c%0d_%0d", i, j), mem1[48 + i * 4 + j], s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
